// File: rtl/scan_chain_master.sv
// scan_chain_master
//   Turns single-cycle host commands into two-phase scan-pad waveforms and
//   returns the bits shifted out of the chain.
//
//   Ports
//     clk, rst_n        clock (rising edge) and asynchronous active-low reset
//     cmd_valid/ready   command handshake. A command transfers on a rising clk
//                       edge where cmd_valid && cmd_ready. cmd_ready is high only
//                       in IDLE. cmd_valid while busy is ignored. cmd_op and
//                       wr_data are sampled only on that transfer edge.
//     cmd_op            00 ROTATE, 01 LOAD_CHIP, 10 LOAD_CHAIN, 11 CAPTURE_ROTATE
//     wr_data           bits to shift into the chain; bit 0 leaves first
//     rd_data/rd_valid  chain contents from the last rotate; rd_valid pulses once
//     busy              inverse of cmd_ready
//     scan_*            pad-level scan waveforms; scan_data_out is serial input
//     dbg_state         current FSM state, for observation only
//
//   Every waveform step lasts PHASE_CYCLES clocks. All outputs come from flops.
//   Pad outputs are computed from the next state, so they line up with the state
//   register.
module scan_chain_master #(
    parameter int CHAIN_LENGTH = 12,
    parameter int PHASE_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [CHAIN_LENGTH-1:0] wr_data,
    output logic [CHAIN_LENGTH-1:0] rd_data,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    scan_phi,
    output logic                    scan_phi_bar,
    output logic                    scan_data_in,
    input  logic                    scan_data_out,
    output logic                    scan_load_chip,
    output logic                    scan_load_chain,
    output logic [3:0]              dbg_state
);

    localparam int N   = CHAIN_LENGTH;
    localparam int P   = PHASE_CYCLES;
    localparam int PCW = $clog2(P + 1);
    localparam int BCW = $clog2(N + 1);

    typedef enum logic [3:0] {
        IDLE, LC_HI, LC_LO,
        LN_EN, LN_PHI, LN_GAP, LN_PHIB, LN_END,
        R_SET, R_PHI, R_GAP, R_PHIB, R_SHIFT
    } state_t;

    state_t         state_q, state_d;
    logic [PCW-1:0] phase_q, phase_d;
    logic [BCW-1:0] bit_q, bit_d;
    logic           capt_q, capt_d;      // rotate follows the chain load
    logic [N-1:0]   shreg_q, shreg_d;
    logic [N-1:0]   cap_q, cap_d;
    logic [N-1:0]   rd_data_q, rd_data_d;
    logic           rd_valid_q, rd_valid_d;
    logic           ready_q, ready_d;
    logic           busy_q, busy_d;
    logic           phi_q, phi_d;
    logic           phib_q, phib_d;
    logic           sdi_q, sdi_d;
    logic           lchip_q, lchip_d;
    logic           lchain_q, lchain_d;
    logic           step_end;
    logic [N:0]     cap_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            bit_q      <= '0;
            capt_q     <= 1'b0;
            shreg_q    <= '0;
            cap_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            phi_q      <= 1'b0;
            phib_q     <= 1'b0;
            sdi_q      <= 1'b0;
            lchip_q    <= 1'b0;
            lchain_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            capt_q     <= capt_d;
            shreg_q    <= shreg_d;
            cap_q      <= cap_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            phi_q      <= phi_d;
            phib_q     <= phib_d;
            sdi_q      <= sdi_d;
            lchip_q    <= lchip_d;
            lchain_q   <= lchain_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = '0;
        bit_d      = bit_q;
        capt_d     = capt_q;
        shreg_d    = shreg_q;
        cap_d      = cap_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        sdi_d      = sdi_q;
        cap_ext    = {scan_data_out, cap_q};
        step_end   = (phase_q == PCW'(P - 1));

        if (state_q != IDLE) begin
            phase_d = step_end ? '0 : phase_q + PCW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    shreg_d = wr_data;
                    capt_d  = (cmd_op == 2'b11);
                    unique case (cmd_op)
                        2'b00: state_d = R_SET;
                        2'b01: state_d = LC_HI;
                        2'b10: state_d = LN_EN;
                        2'b11: state_d = LN_EN;
                    endcase
                end
            end
            LC_HI:   if (step_end) state_d = LC_LO;
            LC_LO:   if (step_end) state_d = IDLE;
            LN_EN:   if (step_end) state_d = LN_PHI;
            LN_PHI:  if (step_end) state_d = LN_GAP;
            LN_GAP:  if (step_end) state_d = LN_PHIB;
            LN_PHIB: if (step_end) state_d = LN_END;
            LN_END:  if (step_end) state_d = capt_q ? R_SET : IDLE;
            R_SET:   if (step_end) state_d = R_PHI;
            R_PHI:   if (step_end) state_d = R_GAP;
            R_GAP:   if (step_end) state_d = R_PHIB;
            R_PHIB:  if (step_end) state_d = R_SHIFT;
            R_SHIFT: begin
                if (step_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BCW'(N - 1)) begin
                        bit_d      = '0;
                        state_d    = IDLE;
                        rd_data_d  = cap_q;
                        rd_valid_d = 1'b1;
                    end else begin
                        bit_d   = bit_q + BCW'(1);
                        state_d = R_SET;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Each bit: sample the chain output before clocking it, and present the
        // next data bit; both happen on the edge entering R_SET.
        if (state_d == R_SET && state_q != R_SET) begin
            cap_d = cap_ext[N:1];
            sdi_d = shreg_d[0];
        end else if (!(state_d inside {R_SET, R_PHI, R_GAP, R_PHIB, R_SHIFT})) begin
            sdi_d = 1'b0;
        end

        ready_d  = (state_d == IDLE);
        busy_d   = (state_d != IDLE);
        phi_d    = (state_d == LN_PHI) || (state_d == R_PHI);
        phib_d   = (state_d == LN_PHIB) || (state_d == R_PHIB);
        lchip_d  = (state_d == LC_HI);
        lchain_d = state_d inside {LN_EN, LN_PHI, LN_GAP, LN_PHIB, LN_END};
    end

    assign cmd_ready       = ready_q;
    assign busy            = busy_q;
    assign rd_data         = rd_data_q;
    assign rd_valid        = rd_valid_q;
    assign scan_phi        = phi_q;
    assign scan_phi_bar    = phib_q;
    assign scan_data_in    = sdi_q;
    assign scan_load_chip  = lchip_q;
    assign scan_load_chain = lchain_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_scan_chain_master.sv
// Bench for scan_chain_master. Two instances run side by side, one with one
// clock per step and one with three, each wired to a small two-phase scan-chain
// chip model. An abstract model tracks chain and chip register contents and
// predicts read-back data and busy durations.
module tb_scan_chain_master;
    localparam int N = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] len;
    } op_rec_t;

    for (genvar g = 0; g < 2; g++) begin : gen_inst
        localparam int P = (g == 0) ? 1 : 3;

        logic         rst_n = 1'b1;
        logic         cmd_valid, cmd_ready, rd_valid, busy;
        logic         phi, phib, sdi, sdo, lchip, lchain;
        logic [1:0]   cmd_op;
        logic [N-1:0] wr_data, rd_data;
        logic [3:0]   dbg_state;
        bit           fin = 1'b0;

        scan_chain_master #(.CHAIN_LENGTH(N), .PHASE_CYCLES(P)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
            .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
            .scan_phi(phi), .scan_phi_bar(phib), .scan_data_in(sdi),
            .scan_data_out(sdo), .scan_load_chip(lchip), .scan_load_chain(lchain),
            .dbg_state(dbg_state)
        );

        // Chip model: master latches on phi, slave on phi_bar; bit 0 faces the
        // master's data input pin.
        logic [N-1:0] chain, master, chip_wr, chip_rd, preset_val;
        logic         preset = 1'b0;
        assign sdo = chain[0];
        always @(posedge phi) master <= lchain ? chip_rd : {sdi, chain[N-1:1]};
        always @(posedge phib or posedge preset) begin
            if (preset) chain <= preset_val;
            else        chain <= master;
        end
        always @(posedge lchip) chip_wr <= chain;

        // Abstract model state and scoreboards
        logic [N-1:0] ref_chain;
        logic [N-1:0] exp_q[$];
        logic [N-1:0] chipw_q[$];
        op_rec_t      len_q[$];

        task automatic do_preset(input logic [N-1:0] v);
            preset_val = v;
            preset = 1'b1;
            #1 preset = 1'b0;
            ref_chain = v;
        endtask

        task automatic push_exp(input logic [1:0] op, input logic [N-1:0] d);
            case (op)
                2'b00: begin
                    exp_q.push_back(ref_chain);
                    ref_chain = d;
                    len_q.push_back({op, 32'(5 * N * P)});
                end
                2'b01: begin
                    chipw_q.push_back(ref_chain);
                    len_q.push_back({op, 32'(2 * P)});
                end
                2'b10: begin
                    ref_chain = chip_rd;
                    len_q.push_back({op, 32'(5 * P)});
                end
                default: begin
                    exp_q.push_back(chip_rd);
                    ref_chain = d;
                    len_q.push_back({op, 32'(5 * P + 5 * N * P)});
                end
            endcase
        endtask

        task automatic wait_ready();
            bit ok = 1'b0;
            for (int i = 0; i < 3000 && !ok; i++) begin
                @(negedge clk);
                if (cmd_ready) ok = 1'b1;
            end
            check($sformatf("p%0d_ready_wait", P), 32'(ok), 32'd1);
        endtask

        task automatic do_op(input logic [1:0] op, input logic [N-1:0] d,
                             input logic [N-1:0] rdv, input bit keep);
            wait_ready();
            chip_rd   = rdv;
            cmd_valid = 1'b1;
            cmd_op    = op;
            wr_data   = d;
            push_exp(op, d);
            @(posedge clk);
            #1;
            if (!keep) cmd_valid = 1'b0;
        endtask

        task automatic check_pads_idle(input string tag);
            check($sformatf("p%0d_%s_pads", P, tag),
                  32'({phi, phib, sdi, lchip, lchain}), 32'd0);
            check($sformatf("p%0d_%s_rd_data", P, tag), 32'(rd_data), 32'd0);
            check($sformatf("p%0d_%s_rd_valid", P, tag), 32'(rd_valid), 32'd0);
            check($sformatf("p%0d_%s_ready", P, tag), 32'(cmd_ready), 32'd1);
            check($sformatf("p%0d_%s_busy", P, tag), 32'(busy), 32'd0);
        endtask

        // Driver
        initial begin
            logic [N-1:0] d;
            bit seen;
            cmd_valid = 1'b0;
            cmd_op    = 2'b00;
            wr_data   = '0;
            chip_rd   = '0;
            #1 rst_n = 1'b0;
            @(negedge clk);
            check_pads_idle("reset");
            do_preset(N'($urandom));
            @(negedge clk);
            rst_n = 1'b1;
            repeat (3) @(negedge clk);
            check($sformatf("p%0d_post_reset_ready", P), 32'(cmd_ready), 32'd1);
            check($sformatf("p%0d_post_reset_state", P), 32'(dbg_state), 32'd0);

            do_op(2'b00, 12'hA5C, 12'h000, 1'b0);
            do_op(2'b01, N'($urandom), 12'h000, 1'b0);
            do_op(2'b11, 12'h0D1, 12'hB18, 1'b0);
            do_op(2'b10, 12'h000, 12'h5A3, 1'b0);
            do_op(2'b00, 12'hFFF, 12'h000, 1'b0);
            do_op(2'b00, 12'h001, 12'h000, 1'b0);
            for (int i = 0; i < 16; i++) begin
                do_op(2'($urandom_range(0, 3)), N'($urandom), N'($urandom), 1'b0);
            end

            // Reset while in the middle of bit 5 of a rotate
            do_op(2'b00, N'($urandom), 12'h000, 1'b0);
            repeat (5 * 5 * P + 2) @(negedge clk);
            #2 rst_n = 1'b0;
            exp_q.delete();
            len_q.delete();
            chipw_q.delete();
            #1;
            check_pads_idle("midop_reset");
            @(negedge clk);
            do_preset(N'($urandom));
            @(negedge clk);
            #2 rst_n = 1'b1;
            do_op(2'b00, 12'h123, 12'h000, 1'b0);
            do_op(2'b00, N'($urandom), 12'h000, 1'b0);

            // cmd_valid held through a whole rotate: next one starts right after rd_valid
            d = N'($urandom);
            do_op(2'b00, d, 12'h000, 1'b1);
            seen = 1'b0;
            for (int i = 0; i < 3000 && !seen; i++) begin
                @(negedge clk);
                if (rd_valid) seen = 1'b1;
            end
            check($sformatf("p%0d_held_rd_valid_seen", P), 32'(seen), 32'd1);
            push_exp(2'b00, d);
            @(negedge clk);
            check($sformatf("p%0d_held_restart", P), 32'(busy), 32'd1);
            cmd_valid = 1'b0;
            do_op(2'b00, N'($urandom), 12'h000, 1'b0);

            wait_ready();
            repeat (2) @(negedge clk);
            check($sformatf("p%0d_drain", P),
                  32'(exp_q.size() + len_q.size() + chipw_q.size()), 32'd0);
            fin = 1'b1;
        end

        // Monitor
        int           busy_cnt, phi_run, phib_run, lchip_run, low_run;
        logic [N-1:0] last_rd, exp_v;
        op_rec_t      rec;
        always @(negedge clk) begin
            if (!rst_n) begin
                busy_cnt  = 0;
                phi_run   = 0;
                phib_run  = 0;
                lchip_run = 0;
                low_run   = 1000;
                last_rd   = '0;
            end else begin
                if (rd_valid) begin
                    check($sformatf("p%0d_rd_expected", P), 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        exp_v = exp_q.pop_front();
                        check($sformatf("p%0d_rd_data", P), 32'(rd_data), 32'(exp_v));
                        last_rd = exp_v;
                    end
                end
                if (busy) begin
                    busy_cnt++;
                end else if (busy_cnt > 0) begin
                    check($sformatf("p%0d_op_expected", P), 32'(len_q.size() > 0), 32'd1);
                    if (len_q.size() > 0) begin
                        rec = len_q.pop_front();
                        check($sformatf("p%0d_busy_len_op%0d", P, rec.op), 32'(busy_cnt), rec.len);
                        if (rec.op == 2'b01) begin
                            check($sformatf("p%0d_chipw_expected", P), 32'(chipw_q.size() > 0), 32'd1);
                            if (chipw_q.size() > 0)
                                check($sformatf("p%0d_chip_wr", P), 32'(chip_wr), 32'(chipw_q.pop_front()));
                        end
                    end
                    check($sformatf("p%0d_rd_hold", P), 32'(rd_data), 32'(last_rd));
                    check($sformatf("p%0d_sdi_idle", P), 32'(sdi), 32'd0);
                    busy_cnt = 0;
                end
                if (phi || phib)
                    check($sformatf("p%0d_phi_overlap", P), 32'(phi && phib), 32'd0);
                if (lchip || lchain)
                    check($sformatf("p%0d_load_overlap", P), 32'(lchip && lchain), 32'd0);
                if (phi) begin
                    if (phi_run == 0) check($sformatf("p%0d_phi_gap", P), 32'(low_run >= P), 32'd1);
                    phi_run++;
                end else if (phi_run > 0) begin
                    check($sformatf("p%0d_phi_width", P), 32'(phi_run), 32'(P));
                    phi_run = 0;
                end
                if (phib) begin
                    if (phib_run == 0) check($sformatf("p%0d_phib_gap", P), 32'(low_run >= P), 32'd1);
                    phib_run++;
                end else if (phib_run > 0) begin
                    check($sformatf("p%0d_phib_width", P), 32'(phib_run), 32'(P));
                    phib_run = 0;
                end
                if (lchip) begin
                    lchip_run++;
                end else if (lchip_run > 0) begin
                    check($sformatf("p%0d_lchip_width", P), 32'(lchip_run), 32'(P));
                    lchip_run = 0;
                end
                low_run = (phi || phib) ? 0 : low_run + 1;
            end
        end
    end

    initial begin
        wait (gen_inst[0].fin && gen_inst[1].fin);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
